// File: rtl/ram_write_demux_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_write_demux_if
// Purpose  : Write-request handshake and byte-latch bus for ram_write_demux.
//            The master raises write requests; the slave (the demux) drives
//            the four active-low byte strobes and the shared data bus.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_write_demux_if #(
   parameter int DW = 8
);
   logic          E_n;
   logic          wr_valid;
   logic          wr_ready;
   logic [1:0]    wr_addr;
   logic [DW-1:0] wr_data;
   logic [3:0]    byte_we_n;
   logic [DW-1:0] byte_d;
   logic          busy;
   logic          done;

   modport master (
      output E_n, wr_valid, wr_addr, wr_data,
      input  wr_ready, byte_we_n, byte_d, busy, done
   );

   modport slave (
      input  E_n, wr_valid, wr_addr, wr_data,
      output wr_ready, byte_we_n, byte_d, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/ram_write_demux.sv
`default_nettype none
// ============================================================================
// Module   : ram_write_demux
// Purpose  : Accepts one byte write per valid/ready handshake, decodes the
//            2-bit address into four active-low byte strobes and sequences
//            each write as SETUP -> STROBE -> HOLD so the byte latches see
//            stable data around a registered, glitch-free write pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ram_write_demux #(
   parameter int DW        = 8,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  wire logic         clk,
   input  wire logic         rst,
   ram_write_demux_if.slave  bus
);

   // Counters hold "cycles remaining minus one", so each phase ends when
   // the counter reads zero. Zero-length phases are skipped entirely.
   localparam bit         C_HAS_SETUP = (SETUP_CYC > 0);
   localparam bit         C_HAS_HOLD  = (HOLD_CYC > 0);
   localparam logic [7:0] C_SETUP_LD  = C_HAS_SETUP ? 8'(SETUP_CYC - 1) : 8'd0;
   localparam logic [7:0] C_PULSE_LD  = 8'(PULSE_CYC - 1);
   localparam logic [7:0] C_HOLD_LD   = C_HAS_HOLD ? 8'(HOLD_CYC - 1) : 8'd0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_STROBE = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    cnt_q,   cnt_d;
   logic [1:0]    addr_q,  addr_d;
   logic [DW-1:0] data_q,  data_d;
   logic [3:0]    we_n_q,  we_n_d;
   logic          done_q,  done_d;

   logic          w_ready;
   logic          w_accept;

   assign w_ready  = (state_q == S_IDLE) && !bus.E_n && !rst;
   assign w_accept = bus.wr_valid && w_ready;

   assign bus.wr_ready  = w_ready;
   assign bus.byte_we_n = we_n_q;
   assign bus.byte_d    = data_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = done_q;

   // Next-state, phase counter, capture and strobe decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               addr_d = bus.wr_addr;
               data_d = bus.wr_data;
               if (C_HAS_SETUP) begin
                  state_d = S_SETUP;
                  cnt_d   = C_SETUP_LD;
               end else begin
                  state_d = S_STROBE;
                  cnt_d   = C_PULSE_LD;
               end
            end
         end
         S_SETUP: begin
            if (cnt_q == 8'd0) begin
               state_d = S_STROBE;
               cnt_d   = C_PULSE_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_STROBE: begin
            if (cnt_q == 8'd0) begin
               if (C_HAS_HOLD) begin
                  state_d = S_HOLD;
                  cnt_d   = C_HOLD_LD;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_HOLD: begin
            if (cnt_q == 8'd0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Strobe is decoded from the next state so the output is a clean
      // register with exactly one bit low while in STROBE.
      we_n_d = 4'b1111;
      if (state_d == S_STROBE) begin
         we_n_d[addr_d] = 1'b0;
      end
   end

   // State and output registers; reset aborts any write in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         addr_q  <= 2'd0;
         data_q  <= '0;
         we_n_q  <= 4'b1111;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_n_q  <= we_n_d;
         done_q  <= done_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_write_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_write_demux
// Purpose  : Self-checking bench for ram_write_demux, default timing (dut_a)
//            and the minimal SETUP=0/PULSE=1/HOLD=0 configuration (dut_b).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_write_demux;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_write_demux_if #(.DW(8)) ifa ();
   ram_write_demux_if #(.DW(8)) ifb ();

   ram_write_demux #(.DW(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   ram_write_demux #(.DW(8), .SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Expected writes, {addr, data}, pushed when the request is driven
   logic [9:0] qa[$];
   logic [9:0] qb[$];
   logic [3:0] prev_a = 4'hF;
   logic [3:0] prev_b = 4'hF;
   logic [9:0] ea, eb;
   logic [3:0] wa, wb;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard for dut_a: each strobe start consumes one expected write
   always @(negedge clk) begin
      if (ifa.byte_we_n !== 4'b1111) begin
         chk("a_onehot", $countones(~ifa.byte_we_n), 1);
         if (prev_a === 4'b1111) begin
            if (qa.size() == 0) begin
               chk("a_sb_unexpected", qa.size(), 1);
            end else begin
               ea = qa.pop_front();
               wa = 4'hF;
               wa[ea[9:8]] = 1'b0;
               chk("a_sb_we", ifa.byte_we_n, wa);
               chk("a_sb_data", ifa.byte_d, ea[7:0]);
            end
         end
      end
      prev_a <= ifa.byte_we_n;
   end

   // Scoreboard for dut_b
   always @(negedge clk) begin
      if (ifb.byte_we_n !== 4'b1111) begin
         chk("b_onehot", $countones(~ifb.byte_we_n), 1);
         if (prev_b === 4'b1111) begin
            if (qb.size() == 0) begin
               chk("b_sb_unexpected", qb.size(), 1);
            end else begin
               eb = qb.pop_front();
               wb = 4'hF;
               wb[eb[9:8]] = 1'b0;
               chk("b_sb_we", ifb.byte_we_n, wb);
               chk("b_sb_data", ifb.byte_d, eb[7:0]);
            end
         end
      end
      prev_b <= ifb.byte_we_n;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int last;
      int bound;
      logic [7:0] d;

      ifa.E_n = 1'b0; ifa.wr_valid = 1'b0; ifa.wr_addr = 2'd0; ifa.wr_data = 8'h00;
      ifb.E_n = 1'b0; ifb.wr_valid = 1'b0; ifb.wr_addr = 2'd0; ifb.wr_data = 8'h00;

      // Reset state
      rst = 1'b1;
      step(); step();
      chk("rst_we_a", ifa.byte_we_n, 4'b1111);
      chk("rst_d_a", ifa.byte_d, 8'h00);
      chk("rst_busy_a", ifa.busy, 1'b0);
      chk("rst_done_a", ifa.done, 1'b0);
      chk("rst_ready_a", ifa.wr_ready, 1'b0);
      chk("rst_we_b", ifb.byte_we_n, 4'b1111);
      rst = 1'b0;
      step();

      // Minimal timing: strobe in cycle 1, done in cycle 2, re-accept at edge 2
      ifb.wr_addr = 2'd3; ifb.wr_data = 8'h3C; ifb.wr_valid = 1'b1;
      qb.push_back({2'd3, 8'h3C});
      #1;
      chk("b_ready0", ifb.wr_ready, 1'b1);
      step();
      ifb.wr_valid = 1'b0;
      chk("b_c1_we", ifb.byte_we_n, 4'b0111);
      chk("b_c1_d", ifb.byte_d, 8'h3C);
      chk("b_c1_done", ifb.done, 1'b0);
      step();
      chk("b_c2_we", ifb.byte_we_n, 4'b1111);
      chk("b_c2_done", ifb.done, 1'b1);
      chk("b_c2_ready", ifb.wr_ready, 1'b1);
      ifb.wr_addr = 2'd0; ifb.wr_data = 8'h5A; ifb.wr_valid = 1'b1;
      qb.push_back({2'd0, 8'h5A});
      step();
      ifb.wr_valid = 1'b0;
      chk("b_c3_we", ifb.byte_we_n, 4'b1110);
      step();
      chk("b_c4_we", ifb.byte_we_n, 4'b1111);
      chk("b_c4_done", ifb.done, 1'b1);
      step();

      // Default timing: addr 2, data A5
      ifa.wr_addr = 2'd2; ifa.wr_data = 8'hA5; ifa.wr_valid = 1'b1;
      qa.push_back({2'd2, 8'hA5});
      #1;
      chk("a1_ready", ifa.wr_ready, 1'b1);
      step();
      ifa.wr_valid = 1'b0;
      chk("a1_c1_d", ifa.byte_d, 8'hA5);
      chk("a1_c1_we", ifa.byte_we_n, 4'b1111);
      chk("a1_c1_busy", ifa.busy, 1'b1);
      step();
      chk("a1_c2_we", ifa.byte_we_n, 4'b1011);
      chk("a1_c2_d", ifa.byte_d, 8'hA5);
      step();
      chk("a1_c3_we", ifa.byte_we_n, 4'b1011);
      step();
      chk("a1_c4_we", ifa.byte_we_n, 4'b1111);
      chk("a1_c4_d", ifa.byte_d, 8'hA5);
      chk("a1_c4_done", ifa.done, 1'b0);
      step();
      chk("a1_c5_done", ifa.done, 1'b1);
      chk("a1_c5_busy", ifa.busy, 1'b0);
      chk("a1_c5_ready", ifa.wr_ready, 1'b1);
      step();
      chk("a1_c6_done", ifa.done, 1'b0);

      // Inputs changed after acceptance must not reach byte_d
      ifa.wr_addr = 2'd0; ifa.wr_data = 8'h12; ifa.wr_valid = 1'b1;
      qa.push_back({2'd0, 8'h12});
      step();
      ifa.wr_valid = 1'b0; ifa.wr_data = 8'hFF; ifa.wr_addr = 2'd3;
      for (int k = 1; k <= 4; k++) begin
         chk("a6_d_hold", ifa.byte_d, 8'h12);
         step();
      end
      chk("a6_done", ifa.done, 1'b1);

      // Back-to-back writes with wr_valid held high
      last = 0;
      for (int i = 0; i < 4; i++) begin
         d = 8'(8'h20 + i);
         ifa.wr_addr = 2'(i); ifa.wr_data = d; ifa.wr_valid = 1'b1;
         qa.push_back({2'(i), d});
         #1;
         bound = 0;
         while (!ifa.wr_ready && bound < 20) begin
            step();
            bound++;
         end
         chk("a2_ready", ifa.wr_ready, 1'b1);
         if (i > 0) chk("a2_spacing", cyc - last, 5);
         last = cyc;
         step();
      end
      ifa.wr_valid = 1'b0;
      for (int k = 0; k < 6; k++) step();

      // Disabled block: request waits, nothing happens
      ifa.E_n = 1'b1; ifa.wr_valid = 1'b1; ifa.wr_addr = 2'd1; ifa.wr_data = 8'h55;
      qa.push_back({2'd1, 8'h55});
      for (int k = 0; k < 10; k++) begin
         step();
         chk("a3_dis_ready", ifa.wr_ready, 1'b0);
         chk("a3_dis_we", ifa.byte_we_n, 4'b1111);
         chk("a3_dis_done", ifa.done, 1'b0);
      end
      ifa.E_n = 1'b0;
      #1;
      chk("a3_en_ready", ifa.wr_ready, 1'b1);
      step();
      ifa.wr_valid = 1'b0;
      step();
      chk("a3_c2_we", ifa.byte_we_n, 4'b1101);
      ifa.E_n = 1'b1;
      step();
      chk("a3_c3_we", ifa.byte_we_n, 4'b1101);
      step();
      chk("a3_c4_we", ifa.byte_we_n, 4'b1111);
      step();
      chk("a3_c5_done", ifa.done, 1'b1);
      chk("a3_c5_ready", ifa.wr_ready, 1'b0);
      ifa.E_n = 1'b0;
      step();

      // Reset during the second strobe cycle
      ifa.wr_addr = 2'd1; ifa.wr_data = 8'h77; ifa.wr_valid = 1'b1;
      qa.push_back({2'd1, 8'h77});
      step();
      ifa.wr_valid = 1'b0;
      step();
      step();
      chk("a4_c3_we", ifa.byte_we_n, 4'b1101);
      rst = 1'b1;
      #1;
      chk("a4_rst_ready", ifa.wr_ready, 1'b0);
      step();
      chk("a4_we", ifa.byte_we_n, 4'b1111);
      chk("a4_d", ifa.byte_d, 8'h00);
      chk("a4_busy", ifa.busy, 1'b0);
      chk("a4_done", ifa.done, 1'b0);
      chk("a4_ready", ifa.wr_ready, 1'b0);
      rst = 1'b0;
      step();
      chk("a4_post_done", ifa.done, 1'b0);
      chk("a4_post_busy", ifa.busy, 1'b0);
      step();

      chk("qa_empty", qa.size(), 0);
      chk("qb_empty", qb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
